// File: rtl/spu_pkg.sv
// SPU shared definitions: opcodes, instruction formats, element widths,
// shift kinds and the Simple Fixed 2 pipeline bundles.
package spu_pkg;

    localparam logic [0:10] OP_SHLH    = 11'b00001011111;
    localparam logic [0:10] OP_SHL     = 11'b00001011011;
    localparam logic [0:10] OP_ROTH    = 11'b00001011100;
    localparam logic [0:10] OP_ROT     = 11'b00001011000;
    localparam logic [0:10] OP_ROTHM   = 11'b00001011101;
    localparam logic [0:10] OP_ROTM    = 11'b00001011001;
    localparam logic [0:10] OP_ROTMAH  = 11'b00001011110;
    localparam logic [0:10] OP_ROTMA   = 11'b00001011010;
    localparam logic [0:10] OP_SHLHI   = 11'b00001111111;
    localparam logic [0:10] OP_SHLI    = 11'b00001111011;
    localparam logic [0:10] OP_ROTHI   = 11'b00001111100;
    localparam logic [0:10] OP_ROTI    = 11'b00001111000;
    localparam logic [0:10] OP_ROTHMI  = 11'b00001111101;
    localparam logic [0:10] OP_ROTMI   = 11'b00001111001;
    localparam logic [0:10] OP_ROTMAHI = 11'b00001111110;
    localparam logic [0:10] OP_ROTMAI  = 11'b00001111010;

    typedef enum logic [2:0] {
        FMT_RR  = 3'd0,
        FMT_RI7 = 3'd2
    } fmt_e;

    localparam int HW_W = 16;
    localparam int WD_W = 32;
    localparam int HW_N = 8;
    localparam int WD_N = 4;

    typedef enum logic [1:0] {
        SH_SHL,
        SH_ROT,
        SH_ROTM,
        SH_ROTMA
    } sh_kind_e;

    typedef struct packed {
        logic [0:10]  op;
        logic [2:0]   fmt;
        logic [6:0]   rt_addr;
        logic [0:127] ra;
        logic [0:127] rb;
        logic [5:0]   icnt;
        logic         we;
    } s1_t;

    typedef struct packed {
        logic [0:127] rt;
        logic [6:0]   addr;
        logic         we;
    } wb_t;

endpackage

// File: rtl/sf2_shifter.sv
// Simple Fixed 2 element shifter: one halfword (low 16 bits) or one word.
// Ports: data/cnt/wide/kind in, res out (halfword result in res[15:0]).
module sf2_shifter
    import spu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [5:0]  cnt,
    input  logic        wide,
    input  sh_kind_e    kind,
    output logic [31:0] res
);

    logic [5:0]         amt;
    logic               over;
    logic [15:0]        h;
    logic [31:0]        hh;
    logic [63:0]        ww;
    logic signed [15:0] sh;
    logic signed [31:0] sw;

    always_comb begin
        h = data[15:0];
        // right-shift forms take the negated count; masking to 5/6 bits
        // gives the mod 32 / mod 64 wrap
        if (kind == SH_ROTM || kind == SH_ROTMA)
            amt = wide ? 6'd0 - cnt : {1'b0, 5'd0 - cnt[4:0]};
        else
            amt = wide ? cnt : {1'b0, cnt[4:0]};
        over = wide ? amt[5] : amt[4];
        hh = {h, h} << amt[3:0];
        ww = {data, data} << amt[4:0];
        sh = $signed(h) >>> amt[3:0];
        sw = $signed(data) >>> amt[4:0];
        res = '0;
        unique case (kind)
            SH_SHL: begin
                if (!over)
                    res = wide ? data << amt[4:0]
                               : {16'h0, h << amt[3:0]};
            end
            SH_ROT: begin
                res = wide ? ww[63:32] : {16'h0, hh[31:16]};
            end
            SH_ROTM: begin
                if (!over)
                    res = wide ? data >> amt[4:0]
                               : {16'h0, h >> amt[3:0]};
            end
            SH_ROTMA: begin
                if (wide)
                    res = over ? {32{data[31]}} : sw;
                else
                    res = {16'h0, over ? {16{h[15]}} : sh};
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/simple_fixed_2.sv
// SPU Simple Fixed 2: 3-stage 128-bit SIMD shift/rotate unit (8x16, 4x32).
// In: clk, reset (async low), op, format, rt_addr, ra, rb, imm, reg_write.
// Out: rt_wb, rt_addr_wb, reg_write_wb. SF2_IMM_FORMS_EN enables RI7 forms.
module simple_fixed_2
    import spu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [0:10]  op,
    input  logic [2:0]   format,
    input  logic [6:0]   rt_addr,
    input  logic [0:127] ra,
    input  logic [0:127] rb,
    input  logic [0:17]  imm,
    input  logic         reg_write,
    output logic [0:127] rt_wb,
    output logic [6:0]   rt_addr_wb,
    output logic         reg_write_wb
);

    s1_t      s1;
    wb_t      s2, s3, s2_d;
    logic     rr, ri, ok, wide;
    sh_kind_e kind;

    logic [31:0]     h_res [HW_N];
    logic [31:0]     w_res [WD_N];
    logic [0:127]    res_h, res_w;
    logic [HW_N-1:0] unused_h;
    logic            unused_ok;

    always_comb begin
        rr = s1.fmt == FMT_RR;
`ifdef SF2_IMM_FORMS_EN
        ri = s1.fmt == FMT_RI7;
`else
        ri = 1'b0;
`endif
        ok   = 1'b0;
        wide = 1'b0;
        kind = SH_SHL;
        unique case (1'b1)
            rr && s1.op == OP_SHLH:    begin ok = 1'b1; kind = SH_SHL; end
            rr && s1.op == OP_ROTH:    begin ok = 1'b1; kind = SH_ROT; end
            rr && s1.op == OP_ROTHM:   begin ok = 1'b1; kind = SH_ROTM; end
            rr && s1.op == OP_ROTMAH:  begin ok = 1'b1; kind = SH_ROTMA; end
            rr && s1.op == OP_SHL:     begin ok = 1'b1; wide = 1'b1; kind = SH_SHL; end
            rr && s1.op == OP_ROT:     begin ok = 1'b1; wide = 1'b1; kind = SH_ROT; end
            rr && s1.op == OP_ROTM:    begin ok = 1'b1; wide = 1'b1; kind = SH_ROTM; end
            rr && s1.op == OP_ROTMA:   begin ok = 1'b1; wide = 1'b1; kind = SH_ROTMA; end
            ri && s1.op == OP_SHLHI:   begin ok = 1'b1; kind = SH_SHL; end
            ri && s1.op == OP_ROTHI:   begin ok = 1'b1; kind = SH_ROT; end
            ri && s1.op == OP_ROTHMI:  begin ok = 1'b1; kind = SH_ROTM; end
            ri && s1.op == OP_ROTMAHI: begin ok = 1'b1; kind = SH_ROTMA; end
            ri && s1.op == OP_SHLI:    begin ok = 1'b1; wide = 1'b1; kind = SH_SHL; end
            ri && s1.op == OP_ROTI:    begin ok = 1'b1; wide = 1'b1; kind = SH_ROT; end
            ri && s1.op == OP_ROTMI:   begin ok = 1'b1; wide = 1'b1; kind = SH_ROTM; end
            ri && s1.op == OP_ROTMAI:  begin ok = 1'b1; wide = 1'b1; kind = SH_ROTMA; end
            default: ok = 1'b0;
        endcase
    end

    for (genvar i = 0; i < HW_N; i++) begin : g_h
        logic [5:0] c;
        assign c = ri ? s1.icnt : {1'b0, s1.rb[HW_W*i+11 +: 5]};
        sf2_shifter u_sh (
            .data ({16'h0, s1.ra[HW_W*i +: HW_W]}),
            .cnt  (c),
            .wide (1'b0),
            .kind (kind),
            .res  (h_res[i])
        );
        assign res_h[HW_W*i +: HW_W] = h_res[i][15:0];
        assign unused_h[i] = |h_res[i][31:16];
    end

    for (genvar j = 0; j < WD_N; j++) begin : g_w
        logic [5:0] c;
        assign c = ri ? s1.icnt : s1.rb[WD_W*j+26 +: 6];
        sf2_shifter u_sh (
            .data (s1.ra[WD_W*j +: WD_W]),
            .cnt  (c),
            .wide (1'b1),
            .kind (kind),
            .res  (w_res[j])
        );
        assign res_w[WD_W*j +: WD_W] = w_res[j];
    end

    // only the count fields of rb and the low imm bits matter
    assign unused_ok = ^{imm[0:11], s1.rb, unused_h};

    always_comb begin
        s2_d      = '0;
        s2_d.rt   = ok ? (wide ? res_w : res_h) : '0;
        s2_d.addr = s1.rt_addr;
        s2_d.we   = ok & s1.we;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1.op      <= op;
            s1.fmt     <= format;
            s1.rt_addr <= rt_addr;
            s1.ra      <= ra;
            s1.rb      <= rb;
            s1.icnt    <= imm[12:17];
            s1.we      <= reg_write;
            s2         <= s2_d;
            s3         <= s2;
        end
    end

    assign rt_wb        = s3.rt;
    assign rt_addr_wb   = s3.addr;
    assign reg_write_wb = s3.we;

endmodule

// File: tb/tb_simple_fixed_2.sv
// Scoreboard bench for simple_fixed_2: directed vectors with hand-computed
// results queued at issue and checked by an independent output monitor.
module tb_simple_fixed_2;

    localparam logic [10:0] SHLH    = 11'b00001011111;
    localparam logic [10:0] SHL     = 11'b00001011011;
    localparam logic [10:0] ROTH    = 11'b00001011100;
    localparam logic [10:0] ROT     = 11'b00001011000;
    localparam logic [10:0] ROTHM   = 11'b00001011101;
    localparam logic [10:0] ROTM    = 11'b00001011001;
    localparam logic [10:0] ROTMAH  = 11'b00001011110;
    localparam logic [10:0] ROTMA   = 11'b00001011010;
    localparam logic [10:0] SHLI    = 11'b00001111011;
    localparam logic [10:0] ROTHI   = 11'b00001111100;
    localparam logic [10:0] ROTI    = 11'b00001111000;
    localparam logic [10:0] ROTMI   = 11'b00001111001;
    localparam logic [10:0] ROTMAI  = 11'b00001111010;
    localparam logic [2:0]  RR = 3'd0;
    localparam logic [2:0]  RI = 3'd2;
    localparam logic [127:0] Z = '0;
`ifdef SF2_IMM_FORMS_EN
    localparam bit IMM = 1'b1;
`else
    localparam bit IMM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [0:10]  op;
    logic [2:0]   format;
    logic [6:0]   rt_addr;
    logic [0:127] ra, rb;
    logic [0:17]  imm;
    logic         reg_write;
    logic [0:127] rt_wb;
    logic [6:0]   rt_addr_wb;
    logic         reg_write_wb;

    simple_fixed_2 dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .format       (format),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .imm          (imm),
        .reg_write    (reg_write),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        int           due;
        logic [127:0] rt;
        logic [6:0]   addr;
        logic         we;
    } exp_t;

    exp_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic issue(input string n, input logic [10:0] o,
                         input logic [2:0] f, input logic [6:0] ad,
                         input logic [127:0] a, input logic [127:0] b,
                         input logic [6:0] i7, input logic rw,
                         input logic [127:0] er, input logic ew);
        exp_t e;
        @(negedge clk);
        op = o; format = f; rt_addr = ad; ra = a; rb = b;
        imm = {11'h5a5, i7}; reg_write = rw;
        e.name = n; e.due = cyc + 3; e.rt = er; e.addr = ad; e.we = ew;
        sb.push_back(e);
    endtask

    task automatic check_zero(input string n);
        ntests++;
        if (rt_wb !== '0 || rt_addr_wb !== 7'd0 || reg_write_wb !== 1'b0) begin
            nfail++;
            $display("FAIL %s: rt_wb=%h addr=%0d we=%b, required all zero",
                     n, rt_wb, rt_addr_wb, reg_write_wb);
        end
    endtask

    // monitor: the unit presents a result every cycle; compare the due one
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset && sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                ntests++;
                if (e.due != cyc) begin
                    nfail++;
                    $display("FAIL %s: checked at cycle %0d, required %0d",
                             e.name, cyc, e.due);
                end else if (rt_wb !== e.rt || rt_addr_wb !== e.addr ||
                             reg_write_wb !== e.we) begin
                    nfail++;
                    $display("FAIL %s: rt_wb=%h addr=%0d we=%b, required rt_wb=%h addr=%0d we=%b",
                             e.name, rt_wb, rt_addr_wb, reg_write_wb,
                             e.rt, e.addr, e.we);
                end
            end
        end
    end

    initial begin
        int w;
        op = '0; format = '0; rt_addr = '0; ra = '0; rb = '0;
        imm = '0; reg_write = 1'b0; reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;

        issue("shlh_1", SHLH, RR, 7'd3, {8{16'h0001}}, {8{16'h0001}}, 7'd0, 1'b1, {8{16'h0002}}, 1'b1);
        issue("shlh_a", SHLH, RR, 7'd10, {8{16'h1234}}, {8{16'h0004}}, 7'd0, 1'b1, {8{16'h2340}}, 1'b1);
        issue("nop", 11'd0, RR, 7'd11, {8{16'h1234}}, {8{16'h0004}}, 7'd0, 1'b1, Z, 1'b0);
        issue("shlh_mod32", SHLH, RR, 7'd12, {8{16'h1234}}, {8{16'h0021}}, 7'd0, 1'b1, {8{16'h2468}}, 1'b1);
        issue("shlh_16", SHLH, RR, 7'd13, {8{16'hFFFF}}, {8{16'h0010}}, 7'd0, 1'b1, Z, 1'b1);
        issue("shlh_lanes", SHLH, RR, 7'd14, {8{16'h0001}},
              {16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7}, 7'd0, 1'b1,
              {16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080}, 1'b1);
        issue("rothm", ROTHM, RR, 7'd15, {8{16'hFFFF}}, {8{16'h001E}}, 7'd0, 1'b1, {8{16'h3FFF}}, 1'b1);
        issue("rotmah", ROTMAH, RR, 7'd16, {8{16'hFFFF}}, {8{16'h001E}}, 7'd0, 1'b1, {8{16'hFFFF}}, 1'b1);
        issue("rotmah_pos", ROTMAH, RR, 7'd17, {8{16'h7FFF}}, {8{16'h001E}}, 7'd0, 1'b1, {8{16'h1FFF}}, 1'b1);
        issue("rotm", ROTM, RR, 7'd18, {4{32'hFFFF0002}}, {4{32'h001E003A}}, 7'd0, 1'b1, {4{32'h03FFFC00}}, 1'b1);
        issue("rotma", ROTMA, RR, 7'd19, {4{32'hFFFF0002}}, {4{32'h001E003A}}, 7'd0, 1'b1, {4{32'hFFFFFC00}}, 1'b1);
        issue("rothm_0", ROTHM, RR, 7'd20, {8{16'hABCD}}, Z, 7'd0, 1'b1, {8{16'hABCD}}, 1'b1);
        issue("rothm_16", ROTHM, RR, 7'd21, {8{16'hFFFF}}, {8{16'h0010}}, 7'd0, 1'b1, Z, 1'b1);
        issue("rotmah_16", ROTMAH, RR, 7'd22, {8{16'h8000}}, {8{16'h0010}}, 7'd0, 1'b1, {8{16'hFFFF}}, 1'b1);
        issue("roth", ROTH, RR, 7'd23, {8{16'h1234}}, {8{16'h0004}}, 7'd0, 1'b1, {8{16'h2341}}, 1'b1);
        issue("rot", ROT, RR, 7'd24, {4{32'h12345678}}, {4{32'h00000008}}, 7'd0, 1'b1, {4{32'h34567812}}, 1'b1);
        issue("shl_32", SHL, RR, 7'd25, {4{32'hFFFFFFFF}}, {4{32'h00000020}}, 7'd0, 1'b1, Z, 1'b1);
        issue("shl_4", SHL, RR, 7'd26, {4{32'h12345678}}, {4{32'h00000004}}, 7'd0, 1'b1, {4{32'h23456780}}, 1'b1);
        issue("shl_mod64", SHL, RR, 7'd27, {4{32'h12345678}}, {4{32'h00000044}}, 7'd0, 1'b1, {4{32'h23456780}}, 1'b1);
        issue("no_write", SHLH, RR, 7'd28, {8{16'h0001}}, {8{16'h0001}}, 7'd0, 1'b0, {8{16'h0002}}, 1'b0);
        issue("unknown", 11'h7FF, RR, 7'd29, {8{16'hFFFF}}, {8{16'h0001}}, 7'd0, 1'b1, Z, 1'b0);
        issue("rr_as_ri7", SHLH, RI, 7'd30, {8{16'h0001}}, {8{16'h0001}}, 7'd1, 1'b1, Z, 1'b0);
        issue("fmt_1", SHLH, 3'd1, 7'd31, {8{16'h0001}}, {8{16'h0001}}, 7'd1, 1'b1, Z, 1'b0);
        issue("ri7_as_rr", ROTI, RR, 7'd32, {4{32'hFFFF0002}}, {4{32'h00000001}}, 7'd1, 1'b1, Z, 1'b0);

        issue("rothi", ROTHI, RI, 7'd40, {4{16'hFFFF, 16'h0002}}, {128{1'b1}}, 7'd1, 1'b1,
              IMM ? {4{16'hFFFF, 16'h0004}} : Z, IMM);
        issue("roti", ROTI, RI, 7'd41, {4{32'hFFFF0002}}, {128{1'b1}}, 7'd1, 1'b1,
              IMM ? {4{32'hFFFE0005}} : Z, IMM);
        issue("shli", SHLI, RI, 7'd42, {4{32'hFFFF0002}}, {128{1'b1}}, 7'd16, 1'b1,
              IMM ? {4{32'h00020000}} : Z, IMM);
        issue("rotmai_34", ROTMAI, RI, 7'd43, {2{32'hFFFF0002, 32'h00030004}}, {128{1'b1}}, 7'd30, 1'b1,
              IMM ? {2{32'hFFFFFFFF, 32'h00000000}} : Z, IMM);
        issue("rothi_neg", ROTHI, RI, 7'd44, {8{16'h0001}}, {128{1'b1}}, 7'h7F, 1'b1,
              IMM ? {8{16'h8000}} : Z, IMM);
        issue("rotmi_neg", ROTMI, RI, 7'd45, {4{32'h80000000}}, {128{1'b1}}, 7'h7E, 1'b1,
              IMM ? {4{32'h20000000}} : Z, IMM);

        issue("pre_rst_a", SHLH, RR, 7'd5, {8{16'h0001}}, {8{16'h0003}}, 7'd0, 1'b1, {8{16'h0008}}, 1'b1);
        issue("pre_rst_b", SHLH, RR, 7'd6, {8{16'h0001}}, {8{16'h0001}}, 7'd0, 1'b1, {8{16'h0002}}, 1'b1);
        issue("pre_rst_c", SHLH, RR, 7'd7, {8{16'h0001}}, {8{16'h0001}}, 7'd0, 1'b1, {8{16'h0002}}, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue("post_rst_shlh", SHLH, RR, 7'd3, {8{16'h0001}}, {8{16'h0001}}, 7'd0, 1'b1, {8{16'h0002}}, 1'b1);
        issue("post_rst_nop", 11'd0, RR, 7'd4, Z, Z, 7'd0, 1'b0, Z, 1'b0);

        w = 0;
        while (sb.size() > 0 && w < 20) begin
            @(posedge clk);
            w++;
        end
        #2;
        if (sb.size() > 0) begin
            ntests++;
            nfail++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
